// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Three-requester Wishbone arbiter (video / CPU / SPI bridge)
//                in front of a single slave. Video has absolute priority and
//                CPU/SPI share the remaining slots round-robin. One transfer
//                is outstanding at a time, and an ack timeout raises a
//                one-cycle error pulse to the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int ADDR_WIDTH     = 20,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    // requester side; bit 0 = video, 1 = CPU, 2 = SPI bridge
    input  logic [2:0]                m_cyc_i,
    input  logic [2:0]                m_stb_i,
    input  logic [2:0]                m_we_i,
    input  logic [3*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [3*DATA_WIDTH-1:0]   m_data_i,
    output logic [DATA_WIDTH-1:0]     m_data_o,
    output logic [2:0]                m_ack_o,
    output logic [2:0]                m_err_o,
    output logic [2:0]                m_stall_o,
    output logic [2:0]                grant_o,
    // slave side
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADDR_WIDTH-1:0]     s_addr_o,
    output logic [DATA_WIDTH-1:0]     s_data_o,
    input  logic [DATA_WIDTH-1:0]     s_data_i,
    input  logic                      s_ack_i,
    input  logic                      s_stall_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_OWN      = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_grant;
    logic [2:0]              w_grant_nxt;
    logic                    r_rr_last;     // 1: SPI granted last, CPU preferred next
    logic                    w_rr_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_drop;        // one-cycle s_cyc_o gap after a timeout
    logic                    w_drop_nxt;
    logic [DATA_WIDTH-1:0]   r_rdata;

    // Owner-selected requester signals
    logic                    w_own_cyc;
    logic                    w_own_stb;
    logic                    w_own_we;
    logic [ADDR_WIDTH-1:0]   w_own_addr;
    logic [DATA_WIDTH-1:0]   w_own_data;

    logic [2:0]              w_winner;
    logic                    w_accept;
    logic                    w_ack;
    logic                    w_timeout;

    // Route the current owner's bus signals; grant is one-hot or zero
    always_comb begin
        w_own_cyc  = 1'b0;
        w_own_stb  = 1'b0;
        w_own_we   = 1'b0;
        w_own_addr = '0;
        w_own_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (r_grant[i]) begin
                w_own_cyc  = m_cyc_i[i];
                w_own_stb  = m_stb_i[i];
                w_own_we   = m_we_i[i];
                w_own_addr = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_own_data = m_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pick the next owner: video first, then CPU/SPI by round-robin bit
    always_comb begin
        w_winner = 3'b000;
        if (m_cyc_i[0]) begin
            w_winner = 3'b001;
        end else if (m_cyc_i[1] && m_cyc_i[2]) begin
            w_winner = r_rr_last ? 3'b010 : 3'b100;
        end else if (m_cyc_i[1]) begin
            w_winner = 3'b010;
        end else if (m_cyc_i[2]) begin
            w_winner = 3'b100;
        end
    end

    // Slave-side and requester-side handshake outputs
    always_comb begin
        s_cyc_o   = (r_state != S_IDLE) && w_own_cyc && !r_drop;
        s_stb_o   = (r_state == S_OWN) && w_own_cyc && w_own_stb && !r_drop;
        s_we_o    = w_own_we;
        s_addr_o  = w_own_addr;
        s_data_o  = w_own_data;
        grant_o   = r_grant;

        w_accept  = s_stb_o && !s_stall_i;
        // A dropped cyc aborts the transfer, so neither ack nor error is reported
        w_ack     = (r_state == S_WAIT_ACK) && w_own_cyc && s_ack_i;
        w_timeout = (r_state == S_WAIT_ACK) && w_own_cyc && !s_ack_i
                    && (r_cnt == C_CNT_LAST);

        m_ack_o   = w_ack     ? r_grant : 3'b000;
        m_err_o   = w_timeout ? r_grant : 3'b000;
        m_data_o  = w_ack     ? s_data_i : r_rdata;

        // Everyone stalls except an owner in OWN, who follows the slave stall
        m_stall_o = 3'b111;
        if ((r_state == S_OWN) && !r_drop) begin
            m_stall_o = ~r_grant | {3{s_stall_i}};
        end
    end

    // Next-state logic for ownership, round-robin and timeout counter
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_last;
        w_cnt_nxt   = r_cnt;
        w_drop_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|m_cyc_i) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = w_winner;
                    if (w_winner[1]) begin
                        w_rr_nxt = 1'b0;
                    end else if (w_winner[2]) begin
                        w_rr_nxt = 1'b1;
                    end
                end
            end
            S_OWN: begin
                if (!w_own_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = 3'b000;
                end else if (w_accept) begin
                    w_state_nxt = S_WAIT_ACK;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_ACK: begin
                if (!w_own_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = 3'b000;
                end else if (s_ack_i) begin
                    w_state_nxt = S_OWN;
                end else if (w_timeout) begin
                    w_state_nxt = S_OWN;
                    w_drop_nxt  = 1'b1;
                end else if (r_cnt != C_CNT_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 3'b000;
            end
        endcase
    end

    // State register with asynchronous reset
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= S_IDLE;
            r_grant   <= 3'b000;
            r_rr_last <= 1'b1;
            r_cnt     <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_last <= w_rr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    // Capture read data on ack so m_data_o holds it afterwards
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rdata <= '0;
        end else if (w_ack) begin
            r_rdata <= s_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed self-checking bench for wb_arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int AW = 20;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              clock_i = 1'b0;
    logic              reset_n_i;
    logic [2:0]        m_cyc_i, m_stb_i, m_we_i;
    logic [3*AW-1:0]   m_addr_i;
    logic [3*DW-1:0]   m_data_i;
    logic [DW-1:0]     m_data_o;
    logic [2:0]        m_ack_o, m_err_o, m_stall_o, grant_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_data_o;
    logic [DW-1:0]     s_data_i;
    logic              s_ack_i, s_stall_i;

    int n_checks = 0;
    int n_errors = 0;
    int early_err;

    wb_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_data_i  (m_data_i),
        .m_data_o  (m_data_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_stall_o (m_stall_o),
        .grant_o   (grant_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .s_stall_i (s_stall_i)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        reset_n_i = 1'b0;
        m_cyc_i   = '0;
        m_stb_i   = '0;
        m_we_i    = '0;
        m_addr_i  = '0;
        m_data_i  = '0;
        s_data_i  = '0;
        s_ack_i   = 1'b0;
        s_stall_i = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_scyc",  32'(s_cyc_o), 32'h0);
        check("rst_stall", 32'(m_stall_o), 32'h7);
        check("rst_data",  32'(m_data_o), 32'h0);
        check("rst_ackerr", 32'({m_ack_o, m_err_o}), 32'h0);

        // CPU and SPI together: CPU first, one idle cycle, then SPI
        reset_n_i = 1'b1;
        m_cyc_i   = 3'b110;
        #1 check("idle_grant", 32'(grant_o), 32'h0);
        tick();
        check("rr_cpu_first", 32'(grant_o), 32'h2);
        check("cpu_stall",    32'(m_stall_o), 32'h5);
        m_cyc_i = 3'b100;
        #1 check("cpu_drop_scyc", 32'(s_cyc_o), 32'h0);
        tick();
        check("dead_cycle", 32'(grant_o), 32'h0);
        tick();
        check("rr_spi_next", 32'(grant_o), 32'h4);
        m_cyc_i = 3'b000;
        tick();
        check("spi_release", 32'(grant_o), 32'h0);

        // All three request: video wins, read with ack two cycles after strobe
        m_cyc_i = 3'b111;
        tick();
        check("video_prio", 32'(grant_o), 32'h1);
        m_stb_i  = 3'b001;
        m_addr_i = {20'h00000, 20'h00000, 20'h08000};
        #1 check("video_stb",  32'(s_stb_o), 32'h1);
        check("video_addr", 32'(s_addr_o), 32'h08000);
        tick();
        m_stb_i = 3'b000;
        #1 check("wait_stall", 32'(m_stall_o), 32'h7);
        check("wait_stb",   32'(s_stb_o), 32'h0);
        tick();
        s_ack_i  = 1'b1;
        s_data_i = 8'h5A;
        #1 check("video_ack",   32'(m_ack_o), 32'h1);
        check("video_rdata", 32'(m_data_o), 32'h5A);
        tick();
        s_ack_i  = 1'b0;
        s_data_i = 8'h00;
        #1 check("rdata_hold", 32'(m_data_o), 32'h5A);
        check("ack_gone",   32'(m_ack_o), 32'h0);
        m_cyc_i = 3'b110;
        tick();
        tick();
        check("rr_after_spi", 32'(grant_o), 32'h2);

        // CPU write, slave never acks, video asks mid-transfer
        m_stb_i  = 3'b010;
        m_we_i   = 3'b010;
        m_addr_i = {20'h00000, 20'h12345, 20'h00000};
        m_data_i = {8'h00, 8'hC3, 8'h00};
        m_cyc_i  = 3'b111;
        #1 check("cpu_wr_bus", 32'({s_we_o, s_stb_o, s_data_o, s_addr_o}), {2'b11, 8'hC3, 20'h12345});
        tick();
        m_stb_i = 3'b000;
        early_err = 0;
        for (int k = 1; k < TO; k++) begin
            if (m_err_o != 3'b000) early_err++;
            tick();
        end
        check("no_early_err", 32'(early_err), 32'h0);
        check("timeout_err",  32'(m_err_o), 32'h2);
        check("no_preempt",   32'(grant_o), 32'h2);
        tick();
        s_ack_i = 1'b1;
        #1 check("to_scyc_gap", 32'(s_cyc_o), 32'h0);
        check("late_ack",    32'({m_ack_o, m_err_o}), 32'h0);
        tick();
        check("to_own_scyc", 32'(s_cyc_o), 32'h1);
        check("own_ack_ign", 32'(m_ack_o), 32'h0);
        s_ack_i = 1'b0;
        m_cyc_i = 3'b101;
        tick();
        check("cpu_idle", 32'(grant_o), 32'h0);
        tick();
        check("video_after", 32'(grant_o), 32'h1);
        m_cyc_i = 3'b100;
        tick();
        tick();
        check("spi_grant", 32'(grant_o), 32'h4);

        // SPI strobe held off by slave stall for five cycles
        m_stb_i   = 3'b100;
        m_we_i    = 3'b000;
        m_addr_i  = {20'hABCDE, 20'h00000, 20'h00000};
        s_stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 check("stall_hold", 32'({s_stb_o, m_stall_o}), 32'hF);
            tick();
        end
        s_stall_i = 1'b0;
        #1 check("stall_release", 32'(m_stall_o), 32'h3);
        check("spi_addr", 32'(s_addr_o), 32'hABCDE);
        tick();
        m_stb_i = 3'b000;
        #1 check("spi_wait", 32'({s_stb_o, m_stall_o}), 32'h7);
        tick();
        s_ack_i  = 1'b1;
        s_data_i = 8'h77;
        #1 check("spi_ack", 32'({m_ack_o, m_data_o}), {21'h0, 3'b100, 8'h77});
        tick();
        s_ack_i = 1'b0;

        // Asynchronous reset during WAIT_ACK
        m_stb_i = 3'b100;
        tick();
        m_stb_i = 3'b000;
        #1 check("pre_rst_scyc", 32'(s_cyc_o), 32'h1);
        #1 reset_n_i = 1'b0;
        #1 check("async_rst", 32'({s_cyc_o, grant_o, m_stall_o}), 32'h07);
        check("async_rst_data", 32'(m_data_o), 32'h0);
        tick();
        reset_n_i = 1'b1;
        m_cyc_i   = 3'b000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ack wait in clock_i cycles (>=2).
REQ-004 SHALL use a single clock, clock_i, with asynchronous active-low reset reset_n_i; all state changes on rising clock_i.
REQ-005 SHALL have ports:
 clock_i  in  1  system clock (64 MHz)
 reset_n_i  in  1  async active-low reset
 m_cyc_i  in  3  requester cycle; bit 0 = video fetch, 1 = CPU, 2 = SPI bridge
 m_stb_i  in  3  requester strobe
 m_we_i  in  3  requester write enable
 m_addr_i  in  3*ADDR_WIDTH  requester addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
 m_data_i  in  3*DATA_WIDTH  requester write data, same packing
 m_data_o  out  DATA_WIDTH  read data, shared by all requesters
 m_ack_o  out  3  per-requester ack
 m_err_o  out  3  per-requester timeout error
 m_stall_o  out  3  per-requester stall
 grant_o  out  3  one-hot current owner, all-zero when idle
 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle/strobe/write
 s_addr_o  out  ADDR_WIDTH  slave address
 s_data_o  out  DATA_WIDTH  slave write data
 s_data_i  in  DATA_WIDTH  slave read data
 s_ack_i, s_stall_i  in  1 each  slave ack/stall

Function
REQ-006 SHALL implement states IDLE, OWN, WAIT_ACK.
REQ-007 IDLE: grant_o=0, s_cyc_o=s_stb_o=0, m_stall_o=3'b111; if any m_cyc_i set, register winner into grant_o and go OWN next cycle.
REQ-008 Priority: video (bit 0) absolute; between CPU and SPI, round-robin via rr_last bit (bit set = SPI last granted, CPU preferred next); rr_last updates only on CPU/SPI grant.
REQ-009 OWN/WAIT_ACK: s_cyc_o, s_we_o, s_addr_o, s_data_o combinationally muxed from owner; non-owners see m_stall_o=1, m_ack_o=0, m_err_o=0.
REQ-010 OWN: s_stb_o = owner m_stb_i; owner m_stall_o = s_stall_i; strobe accepted when s_stb_o & !s_stall_i -> WAIT_ACK, timeout counter cleared to 0.
REQ-011 WAIT_ACK: s_stb_o=0, owner m_stall_o=1 (one outstanding transfer); counter increments per cycle.
REQ-012 s_ack_i in WAIT_ACK: owner m_ack_o=1 same cycle (combinational), m_data_o=s_data_i, return to OWN.
REQ-013 Counter reaching TIMEOUT_CYCLES-1 without ack: owner m_err_o=1 for exactly that cycle, s_cyc_o deasserted next cycle, return to OWN; late ack thereafter ignored.
REQ-014 Owner drops m_cyc_i in OWN: go IDLE next cycle (one dead cycle before re-arbitration).
REQ-015 Owner drops m_cyc_i in WAIT_ACK: abort, s_cyc_o=0 same cycle, go IDLE, pending ack discarded, no m_ack_o/m_err_o.
REQ-016 s_ack_i outside WAIT_ACK SHALL be ignored.
REQ-017 m_data_o SHALL hold last registered read data when no ack; counter width = clog2(TIMEOUT_CYCLES); counter saturates, never wraps.
REQ-018 Ownership is never preempted; video waits at most until current owner drops cyc.

Reset
REQ-019 reset_n_i low SHALL asynchronously force IDLE, grant_o=0, rr_last=1 (CPU preferred), counter=0, m_data_o=0, all ack/err=0, m_stall_o=3'b111, s_cyc_o=s_stb_o=0.
REQ-020 Reset mid-transfer SHALL drop s_cyc_o immediately; no ack/err issued for aborted transfer.
REQ-021 Release of reset SHALL be synchronised externally; first arbitration occurs on first clock_i edge with reset_n_i high.

Verification
REQ-022 Simultaneous CPU+SPI request after reset -> grant_o=3'b010 first; CPU drops cyc -> one IDLE cycle -> grant_o=3'b100.
REQ-023 All three request in IDLE -> grant_o=3'b001; video read addr 0x08000, slave acks 2 cycles after strobe with 0x5A -> m_ack_o=3'b001, m_data_o=0x5A in ack cycle.
REQ-024 CPU owns, video requests mid-transfer -> CPU keeps grant until it drops cyc; video granted 1 cycle after IDLE.
REQ-025 CPU write, slave never acks, TIMEOUT_CYCLES=16 -> m_err_o[1] pulses exactly one cycle 16 cycles after acceptance; later s_ack_i produces no m_ack_o.
REQ-026 s_stall_i held high 5 cycles during SPI strobe -> m_stall_o[2]=1 those cycles, state stays OWN, transfer accepted on first low cycle.
REQ-027 reset_n_i asserted during WAIT_ACK -> s_cyc_o=0 and grant_o=0 without waiting for clock_i edge.
